// File: rtl/pfpu_seq.sv
// PFPU program sequencer: fetch, issue to ALU, delayed register write-back.
// Optional PFPU_SEQ_STATS_EN adds the icount issued-instruction counter.
module pfpu_seq #(
  parameter int PC_W    = 11,
  parameter int MAX_LAT = 5
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc,
  input  logic [24:0]     instr,
  output logic [6:0]      a_addr,
  output logic [6:0]      b_addr,
  output logic [3:0]      alu_op,
  output logic [6:0]      w_addr,
  output logic            w_en,
  output logic            vecout,
  output logic            err_collision,
`ifdef PFPU_SEQ_STATS_EN
  output logic [PC_W:0]   icount,
`endif
  output logic            err_pcovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam logic [3:0] OP_VOUT = 4'd7;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [6:0]      a_q, a_d;
  logic [6:0]      b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic            vout_q, vout_d;
  logic            vsent_q, vsent_d;
  logic            done_q, done_d;
  logic            col_q, col_d;
  logic            ovf_q, ovf_d;
  logic            wen_q, wen_d;
  logic [6:0]      waddr_q, waddr_d;
  logic [MAX_LAT:1] dv_q, dv_d;
  logic [6:0]      da_q [1:MAX_LAT];
  logic [6:0]      da_d [1:MAX_LAT];
  logic [PC_W:0]   cnt_q, cnt_d;

  logic [3:0] opc;
  logic       issue;
  int         lat;

  assign opc   = instr[10:7];
  assign issue = (state_q == S_RUN);

  always_comb begin
    lat = 0;
    unique case (1'b1)
      (opc inside {4'h1, 4'h2, 4'h3}):        lat = 5;
      (opc inside {4'h6, 4'h8, 4'h9}):        lat = 3;
      (opc inside {4'h4, 4'h5, [4'hA:4'hF]}): lat = 2;
      default:                                lat = 0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = 4'd0;
    vout_d  = (op_q == OP_VOUT);
    vsent_d = vsent_q | vout_q;
    done_d  = 1'b0;
    col_d   = col_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    wen_d   = dv_q[1];
    waddr_d = dv_q[1] ? da_q[1] : waddr_q;
    // Delay line advances one slot per cycle; slot 1 feeds w_en next
    for (int i = 1; i < MAX_LAT; i++) begin
      dv_d[i] = dv_q[i+1];
      da_d[i] = da_q[i+1];
    end
    dv_d[MAX_LAT] = 1'b0;
    da_d[MAX_LAT] = 7'd0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (issue && i == lat) begin
        if (dv_d[i]) col_d = 1'b1;
        dv_d[i] = 1'b1;
        da_d[i] = instr[6:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          col_d   = 1'b0;
          ovf_d   = 1'b0;
          vsent_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        state_d = S_RUN;
        pc_d    = pc_q + 1'b1;
      end
      S_RUN: begin
        a_d  = instr[24:18];
        b_d  = instr[17:11];
        op_d = opc;
        pc_d = pc_q + 1'b1;
        if (opc != 4'd0) cnt_d = cnt_q + 1'b1;
        // pc_q == 0 here means the last word of memory is being issued
        if (opc == OP_VOUT) begin
          state_d = S_DRAIN;
        end else if (pc_q == '0) begin
          state_d = S_DRAIN;
          ovf_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dv_q == '0 && (vout_q || vsent_q || ovf_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      vout_q  <= 1'b0;
      vsent_q <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      for (int i = 1; i <= MAX_LAT; i++) da_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      vout_q  <= vout_d;
      vsent_q <= vsent_d;
      done_q  <= done_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      for (int i = 1; i <= MAX_LAT; i++) da_q[i] <= da_d[i];
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign pc            = pc_q;
  assign a_addr        = a_q;
  assign b_addr        = b_q;
  assign alu_op        = op_q;
  assign w_addr        = waddr_q;
  assign w_en          = wen_q;
  assign vecout        = vout_q;
  assign err_collision = col_q;
  assign err_pcovf     = ovf_q;
`ifdef PFPU_SEQ_STATS_EN
  assign icount        = cnt_q;
`endif

endmodule

// File: tb/tb_pfpu_seq.sv
// Scoreboard bench for pfpu_seq: program-level model predicts issue,
// write-back, vecout and done events; a negedge monitor checks them.
module tb_pfpu_seq;

  localparam int PC_W  = 11;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, w_en, vecout;
  logic            err_collision, err_pcovf;
  logic [PC_W-1:0] pc;
  logic [24:0]     instr = '0;
  logic [6:0]      a_addr, b_addr, w_addr;
  logic [3:0]      alu_op;
`ifdef PFPU_SEQ_STATS_EN
  logic [PC_W:0]   icount;
`endif

  pfpu_seq #(.PC_W(PC_W), .MAX_LAT(5)) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pc            (pc),
    .instr         (instr),
    .a_addr        (a_addr),
    .b_addr        (b_addr),
    .alu_op        (alu_op),
    .w_addr        (w_addr),
    .w_en          (w_en),
    .vecout        (vecout),
    .err_collision (err_collision),
`ifdef PFPU_SEQ_STATS_EN
    .icount        (icount),
`endif
    .err_pcovf     (err_pcovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] mem [DEPTH];
  always @(posedge clk) instr <= mem[pc];

  typedef struct {
    int         c;
    logic [6:0] a;
    logic [6:0] b;
    logic [3:0] op;
  } iss_t;
  typedef struct {
    int         c;
    logic [6:0] addr;
  } wr_t;

  iss_t iq[$];
  wr_t  wq[$];
  int   vq[$];
  int   dq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int op_lat(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3: return 5;
      4'h6, 4'h8, 4'h9: return 3;
      4'h0, 4'h7:       return 0;
      default:          return 2;
    endcase
  endfunction

  function automatic logic [24:0] mk(input int a, input int b,
                                     input int op, input int d);
    logic [24:0] w;
    w = {a[6:0], b[6:0], op[3:0], d[6:0]};
    return w;
  endfunction

  // monitor: every DUT event must match the head of its queue
  always @(negedge clk) begin
    if (alu_op != 4'd0) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL issue: unexpected op=%0d at cyc %0d", alu_op, cyc);
      end else begin
        iss_t e;
        e = iq.pop_front();
        if (e.c != cyc || e.a != a_addr || e.b != b_addr || e.op != alu_op) begin
          errors++;
          $display("FAIL issue: got cyc=%0d a=%0d b=%0d op=%0d want cyc=%0d a=%0d b=%0d op=%0d",
                   cyc, a_addr, b_addr, alu_op, e.c, e.a, e.b, e.op);
        end
      end
    end
    if (w_en) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wb: unexpected w_en addr=%0d at cyc %0d", w_addr, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (e.c != cyc || e.addr != w_addr) begin
          errors++;
          $display("FAIL wb: got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                   cyc, w_addr, e.c, e.addr);
        end
      end
    end
    if (vecout) begin
      checks++;
      if (vq.size() == 0) begin
        errors++;
        $display("FAIL vecout: unexpected at cyc %0d", cyc);
      end else begin
        int e;
        e = vq.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL vecout: got cyc=%0d want cyc=%0d", cyc, e);
        end
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done: unexpected at cyc %0d", cyc);
      end else begin
        int e;
        e = dq.pop_front();
        if (e != cyc || busy) begin
          errors++;
          $display("FAIL done: got cyc=%0d busy=%0b want cyc=%0d busy=0",
                   cyc, busy, e);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic gen_rand(input int n);
    clear_mem();
    for (int k = 0; k < n; k++) begin
      int op;
      op = $urandom_range(0, 14);
      if (op >= 7) op++;
      mem[k] = mk($urandom_range(0, 127), $urandom_range(0, 127),
                  op, $urandom_range(0, 127));
    end
    mem[n] = mk($urandom_range(0, 127), $urandom_range(0, 127), 7, 0);
  endtask

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Predict the whole run from the program, then start it.
  // rst_at >= 0: pull reset rst_at cycles after the start cycle.
  // mid >= 0: pulse a (to be ignored) start mid cycles after start.
  task automatic run_prog(input int rst_at, input int mid);
    int s, v, last, vc, entry, lastw, dn, abort, nn;
    bit col;
    logic [6:0] wmap[int];
    @(posedge clk); #1;
    s = cyc;
    v = -1;
    last = DEPTH - 1;
    for (int k = 0; k < DEPTH; k++) begin
      if (mem[k][10:7] == 4'd7) begin
        v = k;
        last = k;
        break;
      end
    end
    abort = (rst_at >= 0) ? s + rst_at + 1 : 32'h7fffffff;
    col = 1'b0;
    nn = 0;
    lastw = 0;
    for (int k = 0; k <= last; k++) begin
      logic [24:0] w;
      logic [3:0] op;
      int c, l;
      w = mem[k];
      op = w[10:7];
      c = s + 3 + k;
      if (op != 4'd0) begin
        nn++;
        if (c < abort) iq.push_back('{c, w[24:18], w[17:11], op});
      end
      l = op_lat(op);
      if (l > 0) begin
        if (wmap.exists(c + l)) col = 1'b1;
        wmap[c + l] = w[6:0];
        if (c + l > lastw) lastw = c + l;
      end
    end
    foreach (wmap[c]) if (c < abort) wq.push_back('{c, wmap[c]});
    vc = (v >= 0) ? s + 4 + v : 0;
    entry = s + 3 + last;
    dn = entry;
    if (vc > dn) dn = vc;
    if (lastw > dn) dn = lastw;
    dn = dn + 1;
    if (v >= 0 && vc < abort) vq.push_back(vc);
    if (dn < abort) dq.push_back(dn);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (rst_at >= 0) begin
      while (cyc < s + rst_at) begin
        @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("reset_outputs",
            int'({busy, done, pc, a_addr, b_addr, alu_op,
                  w_addr, w_en, vecout, err_collision, err_pcovf}), 0);
      repeat (8) @(posedge clk);
      #1;
    end else begin
      while (cyc < dn + 2) begin
        @(posedge clk); #1;
        start = (mid >= 0 && cyc == s + mid);
      end
      start = 1'b0;
      check("err_collision", int'(err_collision), int'(col));
      check("err_pcovf", int'(err_pcovf), int'(v < 0));
`ifdef PFPU_SEQ_STATS_EN
      check("icount", int'(icount), nn);
`endif
    end
    checks++;
    if (iq.size() + wq.size() + vq.size() + dq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: iq=%0d wq=%0d vq=%0d dq=%0d want all 0",
               iq.size(), wq.size(), vq.size(), dq.size());
      iq.delete();
      wq.delete();
      vq.delete();
      dq.delete();
    end
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          int'({busy, done, pc, a_addr, b_addr, alu_op,
                w_addr, w_en, vecout, err_collision, err_pcovf}), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // FADD r3 <= r2 + r2; VECTOUT r3, r3
    clear_mem();
    mem[0] = mk(2, 2, 1, 3);
    mem[1] = mk(3, 3, 7, 0);
    run_prog(-1, -1);

    // FMUL r5 then FABS r6 three cycles later: same write-back cycle
    clear_mem();
    mem[0] = mk(1, 1, 3, 5);
    mem[3] = mk(2, 2, 4, 6);
    mem[4] = mk(5, 6, 7, 0);
    run_prog(-1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("collision_sticky", int'(err_collision), 1);

    // all-NOP memory: pc wraps, no vecout
    clear_mem();
    run_prog(-1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("pcovf_sticky", int'(err_pcovf), 1);
    check("busy_after_ovf", int'(busy), 0);

    // reset two cycles after FMUL issue: its write must vanish
    clear_mem();
    mem[0] = mk(4, 4, 3, 9);
    mem[30] = mk(9, 9, 7, 0);
    run_prog(5, -1);
    gen_rand(6);
    run_prog(-1, -1);

    // start pulsed during RUN is ignored
    gen_rand(20);
    run_prog(-1, 8);

    // 3 ops + 2 NOPs + VECTOUT
    clear_mem();
    mem[0] = mk(1, 2, 1, 10);
    mem[2] = mk(3, 4, 3, 11);
    mem[4] = mk(5, 6, 8, 12);
    mem[5] = mk(10, 11, 7, 0);
    run_prog(-1, -1);

    for (int r = 0; r < 10; r++) begin
      gen_rand($urandom_range(1, 25));
      run_prog(-1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
